// File: rtl/seradd_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seradd_pkg;

    // Width of the arithmetic slice that is time-shared across the operand.
    localparam int NIBBLE_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for the nibble step counter; never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        int nib;
        nib = width / NIBBLE_BITS;
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// 4-bit ripple-carry adder slice; the only arithmetic in the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state or handshake.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    // Explicit bit-by-bit carry ripple from ci through bit 3.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add through one 4-bit slice, one nibble per cycle LSB first. Optional subtract via SERADD_SUB_EN.
// Latency: out_valid rises WIDTH/4 edges after the accepting edge; one op per WIDTH/4+2 cycles.
// Backpressure: accepts only in IDLE (in_ready); result held in DONE until out_ready, no DONE->accept bypass.
module nibble_serial_adder_ctrl
    import seradd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_BITS;
    localparam int CW  = cnt_width(WIDTH);

    // Operand width must split evenly into whole nibbles.
    if ((WIDTH < NIBBLE_BITS) || ((WIDTH % NIBBLE_BITS) != 0)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(NIB - 1));

`ifdef SERADD_SUB_EN
    // Subtract as A + ~B + 1; cin is ignored so cout reads as "no borrow".
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = op_b;
    assign c_load = cin;
`endif

    nibble_add4 u_slice (
        .a  (a_sr[3:0]),
        .b  (b_sr[3:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, step nibbles in RUN, wait for consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one nibble per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= op_a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> NIBBLE_BITS;
            b_sr  <= b_sr >> NIBBLE_BITS;
            // New nibble enters at the top so that after NIB steps nibble 0 sits at the bottom.
            sum_r <= (sum_r >> NIBBLE_BITS) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_BITS));
            carry <= slice_co;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout_r <= slice_co;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef SERADD_SUB_EN
    logic        sub_i;
    logic        sub4;
`endif

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  op_a4;
    logic [3:0]  op_b4;
    logic        cin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef SERADD_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .op_a      (op_a4),
        .op_b      (op_b4),
        .cin       (cin4),
`ifdef SERADD_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
    );

    // Issue one operation on the 16-bit DUT (must be idle) and wait for out_valid.
    // Returns the result seen at the first out_valid, the latency and whether busy held.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output logic [15:0] rs, output logic rc, output int lat,
                          output logic bz);
        op_a     = a;
        op_b     = b;
        cin      = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        bz  = busy;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            bz = bz & busy;
        end
        rs = sum;
        rc = cout;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        op_a4      = '0;
        op_b4      = '0;
        cin4       = 1'b0;
        out_ready4 = 1'b0;
`ifdef SERADD_SUB_EN
        sub_i = 1'b0;
        sub4  = 1'b0;
`endif
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({cout, sum} !== 17'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", {cout, sum}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry_chain;
        logic [15:0] rs; logic rc; int lat; logic bz;
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'h0001, 1'b0, rs, rc, lat, bz);
        checks++; if (lat !== 4) begin errors++; $display("FAIL chain_latency: got %0d want 4", lat); end
        checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL chain_sum: got %h want 0000", rs); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL chain_cout: got %b want 1", rc); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL chain_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_cin_busy;
        logic [15:0] rs; logic rc; int lat; logic bz;
        out_ready = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b1, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h05556) begin errors++; $display("FAIL cin_sum: got %h want 05556", {rc, rs}); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL cin_busy_held: got %b want 1", bz); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cin_busy_clear: got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        logic [15:0] rs; logic rc; int lat; logic bz;
        logic stable_ok, ready_low_ok;
        out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h03333) begin errors++; $display("FAIL bp_sum: got %h want 03333", {rc, rs}); end
        stable_ok    = 1'b1;
        ready_low_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            op_a     = op_a + 16'h0101;
            @(negedge clk);
            if (sum !== 16'h3333 || cout !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
            if (in_ready !== 1'b0) ready_low_ok = 1'b0;
        end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_hold_stable: got %b want 1 (sum=%h)", stable_ok, sum); end
        checks++; if (ready_low_ok !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low: got %b want 1", ready_low_ok); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready); end
        run_op(16'h0F0F, 16'h0101, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h01010) begin errors++; $display("FAIL bp_next_op: got %h want 01010", {rc, rs}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] rs; logic rc; int lat; logic bz;
        logic seen_valid;
        out_ready = 1'b1;
        op_a      = 16'hAAAA;
        op_b      = 16'h5555;
        cin       = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, out_valid, cout, sum} !== 19'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", {busy, out_valid, cout, sum}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result: got %b want 0", seen_valid); end
        run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h00100) begin errors++; $display("FAIL rst_after_op: got %h want 00100", {rc, rs}); end
        @(negedge clk);
    endtask

`ifdef SERADD_SUB_EN
    task automatic test_subtract;
        logic [15:0] rs; logic rc; int lat; logic bz;
        out_ready = 1'b1;
        sub_i     = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h0FFFE) begin errors++; $display("FAIL sub_borrow: got %h want 0FFFE", {rc, rs}); end
        @(negedge clk);
        run_op(16'h0007, 16'h0005, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== 17'h10002) begin errors++; $display("FAIL sub_no_borrow: got %h want 10002", {rc, rs}); end
        @(negedge clk);
        sub_i = 1'b0;
    endtask
`endif

    task automatic test_width4;
        int lat;
        out_ready4 = 1'b1;
        op_a4      = 4'hF;
        op_b4      = 4'h1;
        cin4       = 1'b1;
        in_valid4  = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL w4_latency: got %0d want 1", lat); end
        checks++; if ({cout4, sum4} !== 5'h11) begin errors++; $display("FAIL w4_sum: got %h want 11", {cout4, sum4}); end
        @(negedge clk);
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL w4_return_idle: got %b want 1", in_ready4); end
    endtask

    task automatic test_random;
        logic [15:0] a, b, rs;
        logic        c, rc, bz, taken;
        logic [16:0] exp;
        int          lat, tries;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom_range(0, 1));
`ifdef SERADD_SUB_EN
            sub_i = 1'($urandom_range(0, 1));
            if (sub_i) exp = {1'b0, a} + {1'b0, ~b} + 17'd1;
            else       exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
`else
            exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
`endif
            out_ready = 1'($urandom_range(0, 1));
            run_op(a, b, c, rs, rc, lat, bz);
            checks++; if ({rc, rs} !== exp) begin errors++; $display("FAIL rand_op%0d: got %h want %h (a=%h b=%h c=%b)", n, {rc, rs}, exp, a, b, c); end
            taken = 1'b0;
            tries = 0;
            while (!taken) begin
                out_ready = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                taken = out_ready & out_valid;
                @(negedge clk);
                tries++;
                if (tries > 20) taken = 1'b1;
            end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_end_idle: got %b want 1", in_ready); end
`ifdef SERADD_SUB_EN
        sub_i = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_cin_busy();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERADD_SUB_EN
        test_subtract();
`endif
        test_width4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs one WIDTH-bit addition by time-sharing a single 4-bit ripple-carry slice: one nibble per cycle, LSB first.
- A carry register feeds each nibble's carry-out into the next cycle's carry-in.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area in approximate/partitioned arithmetic flows.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is illegal and must trigger an elaboration-time error.
- NIB, WIDTH/4, derived local constant: number of nibble steps.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  block can accept operands; equals (state==IDLE).
- op_a  input  WIDTH  addend A.
- op_b  input  WIDTH  addend B.
- cin  input  1  carry-in for nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry-out of the top nibble, registered.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; sum, cout, out_valid, busy, nibble counter, carry register and operand shift registers all 0. in_ready reads 1 while in reset.
- Reset mid-operation aborts the transaction. The result is dropped and never presented.
- States:
  - IDLE -> RUN on in_valid & in_ready. At that edge: load op_a/op_b into shift registers, carry<=cin, cnt<=0.
  - RUN: each edge adds the low nibbles of A and B plus carry through the slice. The 4-bit sum shifts into the top of the result register (right shift by 4); A and B shift right by 4; carry<=slice cout; cnt<=cnt+1. When cnt==NIB-1: state->DONE, out_valid<=1, cout<=slice cout.
  - DONE: sum and cout held stable; out_valid=1. On out_ready, next edge -> IDLE and out_valid<=0.
- Latency: out_valid rises exactly NIB edges after the accepting edge.
- Throughput: one operation per NIB+2 cycles with out_ready tied high. No bypass from DONE to a new accept.
- in_valid is ignored outside IDLE. Operand inputs are sampled only at the accepting edge; changes afterwards have no effect.
- out_ready while out_valid=0 has no effect.
- Arithmetic: sum = (op_a + op_b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Nibble-serial carry order must be bit-exact with a full-width adder.
- cnt width = max(1, clog2(NIB)). For WIDTH=4, RUN lasts exactly one cycle.
- sum holds the last result after returning to IDLE, until the next operation overwrites it during RUN. sum is valid only while out_valid=1.

Optional Feature:
- Macro SERADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled at the accepting edge. When sub=1, B is stored inverted and carry<=1 (cin ignored), so sum = op_a - op_b mod 2^WIDTH and cout=1 means no borrow. When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package seradd_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_BITS=4 constant;
  - function computing counter width from WIDTH.
- Sub-module nibble_add4: purely combinational 4-bit ripple-carry slice (a[3:0], b[3:0], ci -> s[3:0], co). It is instantiated once, and is the only place arithmetic is done.
- Controller FSM, counter, shift registers and carry register all live in nibble_serial_adder_ctrl.

Test Plan:
- WIDTH=16, op_a=0xFFFF, op_b=0x0001, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; sum=0x0000, cout=1; in_ready returns 1 one cycle after the out handshake.
- op_a=0x1234, op_b=0x4321, cin=1 -> sum=0x5556, cout=0; busy high from the accept edge until return to IDLE.
- Hold out_ready=0 for 5 cycles after completion, toggling in_valid and op_a meanwhile -> sum/cout stable, in_ready=0, no second accept. Then out_ready=1 -> IDLE; the next accept uses the new operands.
- Assert rst_n=0 asynchronously during RUN after 2 nibbles -> outputs 0 immediately, out_valid never rises for that op. Then op_a=0x00FF, op_b=0x0001 -> sum=0x0100, cout=0.
- SERADD_SUB_EN defined, op_a=0x0005, op_b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0. Then 0x0007-0x0005 -> sum=0x0002, cout=1.
- WIDTH=4: op_a=0xF, op_b=0x1, cin=1 -> sum=0x1, cout=1, out_valid 1 edge after accept. Plus 1000 random WIDTH=16 operations vs a full-width scoreboard with random out_ready backpressure.
